// File: rtl/instruction_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, reads instruction memory over
// req/ack and presents the latched word, its PC and a valid flag to decode.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        Stall_i,
   input  logic        Branch_Taken_i,
   input  logic [31:0] Branch_Target_i,
   output logic [31:0] Instruction_o,
   output logic [6:0]  Opcode_o,
   output logic [31:0] PC_o,
   output logic        Instr_Valid_o,
   output logic        Fetch_Fault_o,
   output logic [1:0]  dbg_state
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic              boot_seen, boot_seen_nx;
   logic [31:0]       pc, pc_nx;
   logic [31:0]       instr, instr_nx;
   logic [WAIT_W-1:0] wait_cnt, wait_nx;
   logic              fault, fault_nx;

   // imem handshake: req stays high with a stable addr (= PC) until the cycle
   // ack is sampled; ack and rdata are only looked at while req is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= BOOT;
         boot_seen <= 1'b0;
         pc        <= RESET_PC;
         instr     <= 32'h0;
         wait_cnt  <= '0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nx;
         boot_seen <= boot_seen_nx;
         pc        <= pc_nx;
         instr     <= instr_nx;
         wait_cnt  <= wait_nx;
         fault     <= fault_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      boot_seen_nx = boot_seen;
      pc_nx        = pc;
      instr_nx     = instr;
      wait_nx      = wait_cnt;
      fault_nx     = fault;
      case (state)
         // The edge that ends reset recovery arms BOOT; the next one starts fetching.
         BOOT: begin
            if (boot_seen) begin
               state_nx = FETCH;
               wait_nx  = '0;
            end else begin
               boot_seen_nx = 1'b1;
            end
         end
         FETCH: begin
            if (imem_ack_i) begin
               instr_nx = imem_rdata_i;
               wait_nx  = '0;
               state_nx = ISSUE;
            end else if (wait_cnt == WAIT_LAST) begin
               fault_nx = 1'b1;
               state_nx = HALT;
            end else begin
               wait_nx = wait_cnt + WAIT_W'(1);
            end
         end
         ISSUE: begin
            if (!Stall_i) begin
               if (Branch_Taken_i && (Branch_Target_i[1:0] != 2'b00)) begin
                  fault_nx = 1'b1;
                  state_nx = HALT;
               end else begin
                  pc_nx    = Branch_Taken_i ? Branch_Target_i : pc + 32'd4;
                  wait_nx  = '0;
                  state_nx = FETCH;
               end
            end
         end
         HALT: begin
            state_nx = HALT;
         end
         default: begin
            state_nx = HALT;
         end
      endcase
   end

   // Outputs decode registered state only; no input reaches an output combinationally.
   assign imem_req_o    = (state == FETCH);
   assign imem_addr_o   = pc;
   assign PC_o          = pc;
   assign Instruction_o = instr;
   assign Instr_Valid_o = (state == ISSUE);
   assign Opcode_o      = Instr_Valid_o ? instr[6:0] : 7'b0;
   assign Fetch_Fault_o = fault;
   assign dbg_state     = state;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Multi-cycle instruction fetch stage that sits directly upstream of the control decoder in the RISC-V core. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It latches the returned word and presents it, with its PC and a valid flag, to decode. While no valid instruction is held, the opcode output is forced to zero, so the control decoder falls into its default case with no writes and no branch.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset; must be word aligned.
- MAX_WAIT, 15, number of consecutive un-acked FETCH cycles tolerated before a fault; legal range 1..255.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserting it forces every register to its reset value immediately.
- imem_req_o  out  1  read request to instruction memory.
- imem_addr_o  out  32  read address; always equals PC_o.
- imem_ack_i  in  1  memory has valid data on imem_rdata_i this cycle.
- imem_rdata_i  in  32  instruction word from memory.
- Stall_i  in  1  decode/execute cannot accept a new instruction; holds ISSUE.
- Branch_Taken_i  in  1  sampled in ISSUE when Stall_i=0; selects Branch_Target_i as next PC.
- Branch_Target_i  in  32  next PC when branch taken.
- Instruction_o  out  32  latched instruction register.
- Opcode_o  out  7  Instruction_o[6:0] when Instr_Valid_o=1, else 7'b0; drives the control decoder OP input.
- PC_o  out  32  address of the instruction being fetched or issued.
- Instr_Valid_o  out  1  Instruction_o holds a valid word for PC_o.
- Fetch_Fault_o  out  1  sticky fault (timeout or misaligned target); cleared only by reset.

## Operation
- States: BOOT, FETCH, ISSUE, HALT. Reset value: BOOT.
- BOOT: all outputs idle for exactly one cycle, then → FETCH.
- FETCH:
  - imem_req_o=1 and imem_addr_o=PC_o, held stable until ack.
  - On imem_ack_i=1: Instruction_o ← imem_rdata_i, wait counter ← 0, → ISSUE.
  - Without ack: wait counter increments. If the counter equals MAX_WAIT-1 this cycle, Fetch_Fault_o ← 1 and → HALT.
  - Ack takes priority over timeout in the same cycle.
- ISSUE:
  - imem_req_o=0, Instr_Valid_o=1.
  - Stall_i=1: hold everything; Instruction_o and PC_o are unchanged.
  - Stall_i=0, Branch_Taken_i=0: PC ← PC+4 (32-bit modular; 32'hFFFF_FFFC wraps to 0), → FETCH.
  - Stall_i=0, Branch_Taken_i=1, Branch_Target_i[1:0]=0: PC ← Branch_Target_i, → FETCH.
  - Stall_i=0, Branch_Taken_i=1, Branch_Target_i[1:0]≠0: Fetch_Fault_o ← 1, PC unchanged, → HALT.
- HALT: imem_req_o=0, Instr_Valid_o=0, Opcode_o=0; stays in HALT until reset.
- imem_ack_i outside FETCH is ignored; it has no state effect.
- Wait counter width: clog2(MAX_WAIT+1) bits; it is cleared on every entry to FETCH.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=PC_o=RESET_PC, Instruction_o=0, Opcode_o=0, Instr_Valid_o=0, Fetch_Fault_o=0, wait counter=0.
- Reset mid-fetch: imem_req_o drops asynchronously with reset. An ack arriving during or after reset is ignored until FETCH is re-entered.
- All outputs are registered or decoded from registered state only. There is no combinational input→output path.
- First request: imem_req_o rises at the 2nd rising edge after reset deasserts (BOOT lasts one cycle).
- Zero-wait memory (ack in the first FETCH cycle): one instruction per 2 cycles, FETCH then ISSUE.
- Instr_Valid_o rises on the edge that samples ack. It falls on the edge that leaves ISSUE.
- Each memory wait cycle adds one cycle of latency. Each stalled cycle adds one cycle in ISSUE.
- Fault timing: Fetch_Fault_o rises on the MAX_WAIT-th consecutive un-acked FETCH edge. imem_req_o is 0 from the following cycle.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0033 at 0x0040_0000 and 32'h0050_0093 at 0x0040_0004 → Opcode_o 0x33 then 0x13, valid every other cycle, PC_o 0x00400000 then 0x00400004.
- Ack delayed 3 cycles per fetch, MAX_WAIT=15 → no fault; each instruction takes 5 cycles; imem_addr_o stable throughout the wait.
- Stall_i=1 for 4 cycles in ISSUE → Instruction_o, PC_o and Instr_Valid_o=1 all held; the next fetch starts 1 cycle after Stall_i falls.
- Branch_Taken_i=1 with target 0x0040_0100 → next imem_addr_o=0x00400100. Target 0x0040_0102 → Fetch_Fault_o=1, HALT, imem_req_o=0 permanently.
- Never ack, MAX_WAIT=4 → fault after 4 FETCH cycles. Ack on exactly the 4th cycle → no fault, instruction issued.
- PC forced to 0xFFFF_FFFC via branch → next fetch at 0x0000_0000. Reset asserted mid-wait → req low immediately; restart at RESET_PC after BOOT.
